// File: rtl/block_refill_unit.sv
// Miss-refill engine: fetches the four words of a cache block from word-wide memory and presents the assembled line.
// Optional macro CRITICAL_WORD_FIRST_EN: fetch starts at the requested word and critValid pulses early.
module block_refill_unit #(
    parameter int ADDR_W          = 15,
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              refillReq,
    input  logic [ADDR_W-1:0]                 refillAddr,
    output logic                              refillBusy,
    output logic [WORD_W*WORDS_PER_BLOCK-1:0] refillData,
    output logic                              refillValid,
    output logic [WORD_W-1:0]                 critData,
    output logic                              critValid,
    output logic                              memReadReq,
    output logic [ADDR_W-1:0]                 memReadAddress,
    input  logic [WORD_W-1:0]                 memReadData,
    input  logic                              memReadValid
);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]              stateReg, stateNext;
    logic [ADDR_W-OFF_W-1:0] baseReg;
    logic [OFF_W-1:0]        reqOffReg;
    logic [OFF_W-1:0]        countReg;
    logic [ADDR_W-1:0]       addrReg;
    logic [WORD_W-1:0]       lineReg [WORDS_PER_BLOCK];
    logic [OFF_W-1:0]        firstOff, fetchOff, nextOff;
    logic                    lastWord;

    // Offsets are OFF_W wide, so the wrap inside the block is implicit.
`ifdef CRITICAL_WORD_FIRST_EN
    logic critValidReg;
    assign firstOff = refillAddr[OFF_W-1:0];
    assign fetchOff = reqOffReg + countReg;
    assign nextOff  = reqOffReg + countReg + OFF_W'(1);
`else
    assign firstOff = '0;
    assign fetchOff = countReg;
    assign nextOff  = countReg + OFF_W'(1);
`endif

    assign lastWord = (countReg == OFF_W'(WORDS_PER_BLOCK - 1));

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (refillReq) stateNext = ISSUE;
            ISSUE:   stateNext = WAIT;
            WAIT:    if (memReadValid) stateNext = lastWord ? DONE : ISSUE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg  <= IDLE;
            baseReg   <= '0;
            reqOffReg <= '0;
            countReg  <= '0;
            addrReg   <= '0;
            for (int i = 0; i < WORDS_PER_BLOCK; i++) lineReg[i] <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
            critValidReg <= 1'b0;
`endif
        end else begin
            stateReg <= stateNext;
`ifdef CRITICAL_WORD_FIRST_EN
            critValidReg <= 1'b0;
`endif
            case (stateReg)
                IDLE: begin
                    if (refillReq) begin
                        baseReg   <= refillAddr[ADDR_W-1:OFF_W];
                        reqOffReg <= refillAddr[OFF_W-1:0];
                        countReg  <= '0;
                        addrReg   <= {refillAddr[ADDR_W-1:OFF_W], firstOff};
                        for (int i = 0; i < WORDS_PER_BLOCK; i++) lineReg[i] <= '0;
                    end
                end
                WAIT: begin
                    // Returns outside WAIT are stale or spurious and never reach the line.
                    if (memReadValid) begin
                        lineReg[fetchOff] <= memReadData;
`ifdef CRITICAL_WORD_FIRST_EN
                        if (countReg == '0) critValidReg <= 1'b1;
`endif
                        if (!lastWord) begin
                            countReg <= countReg + OFF_W'(1);
                            addrReg  <= {baseReg, nextOff};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_line
            assign refillData[gi*WORD_W +: WORD_W] = lineReg[gi];
        end
    endgenerate

    assign memReadReq     = (stateReg == ISSUE);
    assign memReadAddress = addrReg;
    assign refillBusy     = (stateReg != IDLE);
    assign refillValid    = (stateReg == DONE);
    assign critData       = lineReg[reqOffReg];
`ifdef CRITICAL_WORD_FIRST_EN
    assign critValid      = critValidReg;
`else
    assign critValid      = refillValid;
`endif

endmodule
